// File: rtl/count_sequencer.sv
// Run/pause/step sequencer for a bounded up/down counter; buttons are synchronized and edge-detected here.
// Optional COUNT_SEQ_PINGPONG_EN: with wrap_en=0 the counter bounces off its bounds instead of stopping in DONE.
module count_sequencer #(
    parameter int CNT_WIDTH   = 4,
    parameter int MAX_VAL     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_i,
    input  logic                 btn_go,
    input  logic                 btn_step,
    input  logic                 btn_clr,
    input  logic                 dir,
    input  logic                 wrap_en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 running,
    output logic                 paused,
    output logic                 done,
    output logic                 div_rst
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_VAL);
    localparam int GO = 0, STEP = 1, CLR = 2;

    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          count_q, count_d;
    logic [SYNC_STAGES-1:0][2:0]   sync_q, sync_d;
    logic [2:0]                    hist_q, hist_d;
    logic [2:0]                    evt_q, evt_d;
    logic                          running_q, running_d;
    logic                          paused_q, paused_d;
    logic                          done_q, done_d;
    logic                          div_rst_q, div_rst_d;
`ifdef COUNT_SEQ_PINGPONG_EN
    logic                          dir_q, dir_d;
`endif

    logic                          adv_down, at_bound, adv_to_done, adv_flip, do_adv;
    logic [CNT_WIDTH-1:0]          adv_cnt;

    // Synchronizers and history reset high so a button held through reset gives no edge.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {btn_clr, btn_step, btn_go};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        hist_d = sync_q[SYNC_STAGES-1];
        evt_d  = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Outcome of a single advance from the current count.
    always_comb begin
        adv_down = dir;
`ifdef COUNT_SEQ_PINGPONG_EN
        if (state_q != ST_IDLE) adv_down = dir_q;
`endif
        at_bound    = adv_down ? (count_q == '0) : (count_q == MAX_C);
        adv_to_done = 1'b0;
        adv_flip    = 1'b0;
        adv_cnt     = count_q;
        if (!at_bound) begin
            adv_cnt = adv_down ? count_q - 1'b1 : count_q + 1'b1;
        end else if (wrap_en) begin
            adv_cnt = adv_down ? MAX_C : '0;
        end else begin
`ifdef COUNT_SEQ_PINGPONG_EN
            adv_flip = 1'b1;
            adv_cnt  = adv_down ? count_q + 1'b1 : count_q - 1'b1;
`else
            adv_to_done = 1'b1;
`endif
        end
    end

    // Next state: one event per cycle, clr > go > step > tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        do_adv  = 1'b0;
`ifdef COUNT_SEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (evt_q[CLR]) begin
            state_d = ST_IDLE;
            count_d = '0;
`ifdef COUNT_SEQ_PINGPONG_EN
            dir_d   = dir;
`endif
        end else if (evt_q[GO]) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
`ifdef COUNT_SEQ_PINGPONG_EN
                    dir_d   = dir;
`endif
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default: begin
                    state_d = ST_RUN;
                    count_d = '0;
`ifdef COUNT_SEQ_PINGPONG_EN
                    dir_d   = dir;
`endif
                end
            endcase
        end else if (evt_q[STEP]) begin
            do_adv = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
        end else begin
            do_adv = tick_i && (state_q == ST_RUN);
        end

        if (do_adv) begin
            count_d = adv_cnt;
            if (adv_to_done) state_d = ST_DONE;
`ifdef COUNT_SEQ_PINGPONG_EN
            if (adv_flip) dir_d = ~adv_down;
`else
            if (adv_flip) state_d = state_q;
`endif
        end
    end

    // Registered outputs follow the next state so they change on the transition edge.
    always_comb begin
        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
        done_d    = (state_d == ST_DONE);
        div_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            sync_q    <= '1;
            hist_q    <= '1;
            evt_q     <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            div_rst_q <= 1'b1;
`ifdef COUNT_SEQ_PINGPONG_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            evt_q     <= evt_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            done_q    <= done_d;
            div_rst_q <= div_rst_d;
`ifdef COUNT_SEQ_PINGPONG_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;
    assign div_rst = div_rst_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a cycle-level behavioural model and literal spot checks.
module tb_count_sequencer;
    localparam int S    = 2;
    localparam int MAXV = 15;
`ifdef COUNT_SEQ_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, tick_i = 1'b0;
    logic       btn_go = 1'b0, btn_step = 1'b0, btn_clr = 1'b0;
    logic       dir = 1'b0, wrap_en = 1'b1;
    logic [3:0] count;
    logic       running, paused, done, div_rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_sequencer #(.CNT_WIDTH(4), .MAX_VAL(MAXV), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i),
        .btn_go(btn_go), .btn_step(btn_step), .btn_clr(btn_clr),
        .dir(dir), .wrap_en(wrap_en),
        .count(count), .running(running), .paused(paused), .done(done), .div_rst(div_rst)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0=IDLE 1=RUN 2=PAUSE 3=DONE; button level history, newest sample in bit 0.
    int          m_cnt, m_st;
    bit          m_pdir;
    logic [S+1:0] hg, hs, hc;
    bit          eg, es, ec;

    task automatic adv_model();
        bit down;
        down = (PP && m_st != 0) ? m_pdir : dir;
        if (!down) begin
            if (m_cnt < MAXV) m_cnt++;
            else if (wrap_en) m_cnt = 0;
            else if (PP) begin m_pdir = 1'b1; m_cnt--; end
            else m_st = 3;
        end else begin
            if (m_cnt > 0) m_cnt--;
            else if (wrap_en) m_cnt = MAXV;
            else if (PP) begin m_pdir = 1'b0; m_cnt++; end
            else m_st = 3;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_st = 0; m_pdir = 1'b0;
            hg = '1; hs = '1; hc = '1;
        end else begin
            // An edge sampled at clock k-(S+1) is acted on at clock k.
            eg = hg[S] & ~hg[S+1];
            es = hs[S] & ~hs[S+1];
            ec = hc[S] & ~hc[S+1];
            hg = {hg[S:0], btn_go};
            hs = {hs[S:0], btn_step};
            hc = {hc[S:0], btn_clr};
            if (ec) begin
                m_st = 0; m_cnt = 0; m_pdir = dir;
            end else if (eg) begin
                if (m_st == 1) m_st = 2;
                else begin
                    if (m_st == 3) m_cnt = 0;
                    if (m_st == 0 || m_st == 3) m_pdir = dir;
                    m_st = 1;
                end
            end else if (es) begin
                if (m_st == 0 || m_st == 2) adv_model();
            end else if (tick_i && m_st == 1) begin
                adv_model();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_count", count, m_cnt);
        chk("m_running", running, m_st == 1);
        chk("m_paused", paused, m_st == 2);
        chk("m_done", done, m_st == 3);
        chk("m_div_rst", div_rst, m_st != 1);
    end

    task automatic tick();
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    task automatic press(input int which);
        if (which == 0) btn_go = 1'b1;
        else if (which == 1) btn_step = 1'b1;
        else btn_clr = 1'b1;
        repeat (6) @(negedge clk);
        btn_go = 1'b0; btn_step = 1'b0; btn_clr = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n;
        int pp14[5];
        pp14 = '{14, 15, 14, 13, 12};

        // Go held through reset must not register an edge.
        btn_go = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_go_count", count, 0);
        chk("held_go_running", running, 0);
        chk("held_go_div_rst", div_rst, 1);
        btn_go = 1'b0;
        repeat (6) @(negedge clk);

        btn_go = 1'b1;
        n = 0;
        while (!running && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("go_latency", n, S + 2);
        chk("go_div_rst", div_rst, 0);
        @(negedge clk);
        btn_go = 1'b0;
        repeat (6) @(negedge clk);

        // Wrapping up-count.
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("wrap_count", count, i % 16);
        end

`ifndef COUNT_SEQ_PINGPONG_EN
        wrap_en = 1'b0;
        repeat (13) tick();
        chk("stop_count14", count, 14);
        tick();
        chk("stop_count15", count, 15);
        chk("stop_running15", running, 1);
        tick();
        chk("stop_done", done, 1);
        chk("stop_done_div_rst", div_rst, 1);
        chk("stop_held", count, 15);
        tick();
        chk("stop_held2", count, 15);
        press(0);
        chk("done_go_count", count, 0);
        chk("done_go_running", running, 1);
`endif

        // Pause and single-step.
        press(2);
        chk("clr_idle_count", count, 0);
        press(0);
        wrap_en = 1'b1;
        repeat (5) tick();
        chk("pause_pre", count, 5);
        press(0);
        chk("pause_flag", paused, 1);
        dir = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            press(1);
            chk("pause_step", count, PP ? 5 + k : 5 - k);
        end
        tick();
        tick();
        chk("pause_tick_count", count, PP ? 8 : 2);
        chk("pause_div_rst", div_rst, 1);

        // clr, go and tick all landing in one cycle mid-RUN.
        dir = 1'b0;
        press(0);
        tick();
        chk("pre_clr_running", running, 1);
        btn_clr = 1'b1;
        btn_go  = 1'b1;
        repeat (3) @(negedge clk);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_running", running, 0);
        chk("clr_paused", paused, 0);
        chk("clr_div_rst", div_rst, 1);
        repeat (3) @(negedge clk);
        btn_clr = 1'b0;
        btn_go  = 1'b0;
        repeat (6) @(negedge clk);

        // Step ignored in RUN, then async reset mid-run.
        press(0);
        press(1);
        chk("run_step_ignored", count, 0);
        tick();
        tick();
        chk("pre_rst_count", count, 2);
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_div_rst", div_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

`ifdef COUNT_SEQ_PINGPONG_EN
        wrap_en = 1'b0;
        dir = 1'b0;
        press(0);
        repeat (13) tick();
        chk("pp_start", count, 13);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pp_count", count, pp14[k]);
            chk("pp_done", done, 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
